// File: rtl/key_pkg.sv
// Shared definitions for the push-button arbiter slice.
//   NKEYS    : number of button lines handled by the arbiter
//   state_t  : arbiter FSM states (IDLE = waiting, ISSUE = code held for consumer)
//   onehot4  : converts a 2-bit grant index into the 4-bit one-hot code
package key_pkg;

    localparam int unsigned NKEYS = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    function automatic logic [NKEYS-1:0] onehot4(input logic [1:0] grant);
        logic [NKEYS-1:0] v;
        v        = '0;
        v[grant] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key front end: 2-flop synchroniser, debounce counter and press detector.
// A level change on the synchronised line is accepted only after it has been
// seen for DB_CYCLES consecutive clocks; any return to the accepted level
// restarts the count.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   key  in  raw asynchronous button line, active high
//   rise out one-cycle pulse when the debounced level goes 0 -> 1
module key_debounce #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned DB_W      = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic rise
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= key;
            s2       <= s1;
            stable_d <= stable;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Releases are debounced too, but only presses are reported.
    assign rise = stable & ~stable_d;

endmodule

// File: rtl/key_onehot_arbiter.sv
// Push-button request arbiter feeding a 4-to-2 enabled encoder.
// Each debounced press is latched as a pending request; requests are issued
// one at a time as a one-hot code on D with EN, chosen round-robin starting at
// ptr, and held until the consumer acknowledges.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   key      in   4 raw button lines, active high
//   ack      in   consumer has taken the current code (sampled only in ISSUE)
//   D        out  one-hot code, zero when idle
//   EN       out  valid, high exactly while D != 0
//   pending  out  presses latched but not yet issued
//   overrun  out  sticky: press arrived while that key was already pending
module key_onehot_arbiter
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned DB_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key,
    input  logic             ack,
    output logic [NKEYS-1:0] D,
    output logic             EN,
    output logic [NKEYS-1:0] pending,
    output logic             overrun
);

    logic [NKEYS-1:0] rise;
    logic [NKEYS-1:0] clr;
    logic [NKEYS-1:0] d_next;
    logic [NKEYS-1:0] pend_next;
    logic             en_next;
    logic             ovr_next;
    logic [1:0]       ptr;
    logic [1:0]       ptr_next;
    logic [1:0]       grant;
    logic [1:0]       grant_next;
    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             pick_valid;
    state_t           state;
    state_t           state_next;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce #(
            .DB_CYCLES(DB_CYCLES),
            .DB_W     (DB_W)
        ) u_db (
            .clk (clk),
            .rst (rst),
            .key (key[i]),
            .rise(rise[i])
        );
    end

    // Round-robin search: first pending bit at ptr, ptr+1, ... (2-bit add wraps mod 4).
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int unsigned k = 0; k < NKEYS; k++) begin
            idx = ptr + 2'(k);
            if (!pick_valid && pending[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        d_next     = D;
        en_next    = EN;
        ptr_next   = ptr;
        grant_next = grant;
        clr        = '0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_next = pick;
                    clr        = onehot4(pick);
                    d_next     = onehot4(pick);
                    en_next    = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ack) begin
                    d_next     = '0;
                    en_next    = 1'b0;
                    ptr_next   = grant + 2'd1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A new press on the bit being granted this cycle re-arms it (set wins)
        // and is not an overrun, since the previous request is being consumed.
        pend_next = (pending & ~clr) | rise;
        ovr_next  = overrun | (|(rise & pending & ~clr));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            D       <= '0;
            EN      <= 1'b0;
            ptr     <= '0;
            grant   <= '0;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            D       <= d_next;
            EN      <= en_next;
            ptr     <= ptr_next;
            grant   <= grant_next;
            pending <= pend_next;
            overrun <= ovr_next;
        end
    end

endmodule

// File: tb/tb_key_onehot_arbiter.sv
// Self-checking bench for key_onehot_arbiter (DB_CYCLES = 4).
// A behavioural model steps alongside the DUT every clock and is compared on
// every cycle; directed table vectors and hand sequences check the corner cases.
module tb_key_onehot_arbiter;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ack;
    logic [3:0] key;
    logic [3:0] D;
    logic       EN;
    logic [3:0] pending;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_onehot_arbiter #(
        .DB_CYCLES(DB),
        .DB_W     (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .ack    (ack),
        .D      (D),
        .EN     (EN),
        .pending(pending),
        .overrun(overrun)
    );

    // ---------------- behavioural model ----------------
    bit [3:0] m_s1, m_s2, m_stb, m_stbd, m_pend, m_d;
    int       m_run [4];
    bit       m_en, m_ov, m_busy;
    int       m_ptr, m_g;

    task automatic model_clear();
        m_s1 = 0; m_s2 = 0; m_stb = 0; m_stbd = 0; m_pend = 0; m_d = 0;
        m_en = 0; m_ov = 0; m_busy = 0; m_ptr = 0; m_g = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        bit [3:0] press;
        bit [3:0] taken;
        bit       found;
        if (rst) begin
            model_clear();
            return;
        end
        press  = m_stb & ~m_stbd;
        taken  = 0;
        m_stbd = m_stb;
        // A level is accepted after DB consecutive samples that disagree with it.
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_stb[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_stb[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = key;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && m_pend[(m_ptr + k) % 4]) begin
                    m_g   = (m_ptr + k) % 4;
                    found = 1;
                end
            end
            if (found) begin
                taken    = 4'(1 << m_g);
                m_d      = taken;
                m_en     = 1;
                m_busy   = 1;
            end
        end else if (ack) begin
            m_d    = 0;
            m_en   = 0;
            m_busy = 0;
            m_ptr  = (m_g + 1) % 4;
        end
        if ((press & m_pend & ~taken) != 0) m_ov = 1;
        m_pend = (m_pend & ~taken) | press;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model{D,EN,pending,overrun}", {22'd0, D, EN, pending, overrun},
              {22'd0, m_d, m_en, m_pend, m_ov});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_en(input string name, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!EN && n < max);
        check(name, {31'd0, EN}, 32'd1);
    endtask

    typedef struct {
        logic [3:0] key;
        logic       ack;
        int         n;
        logic [3:0] d;
        logic       en;
        logic [3:0] pend;
        logic       ov;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int       n;
        int       cnt;
        logic     prev_en;
        logic [3:0] seq [4];
        int       hold [4];
        logic [3:0] lvl;

        tbl[0] = '{4'b0001, 1'b0, 6,  4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[1] = '{4'b0001, 1'b0, 1,  4'b0000, 1'b0, 4'b0001, 1'b0};
        tbl[2] = '{4'b0001, 1'b0, 1,  4'b0001, 1'b1, 4'b0000, 1'b0};
        tbl[3] = '{4'b0001, 1'b0, 3,  4'b0001, 1'b1, 4'b0000, 1'b0};
        tbl[4] = '{4'b0001, 1'b1, 1,  4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[5] = '{4'b0000, 1'b0, 10, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[6] = '{4'b0010, 1'b0, 3,  4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[7] = '{4'b0000, 1'b0, 10, 4'b0000, 1'b0, 4'b0000, 1'b0};

        model_clear();
        rst = 1'b1; key = 4'b0; ack = 1'b0;
        #1;
        check("reset D", {28'd0, D}, 32'd0);
        check("reset EN/overrun", {30'd0, EN, overrun}, 32'd0);
        check("reset pending", {28'd0, pending}, 32'd0);
        ticks(2);
        rst = 1'b0;

        // Tests 1 and 2: latency, hold, ack, glitch rejection
        for (int v = 0; v < 8; v++) begin
            key = tbl[v].key;
            ack = tbl[v].ack;
            ticks(tbl[v].n);
            check($sformatf("vec%0d D", v), {28'd0, D}, {28'd0, tbl[v].d});
            check($sformatf("vec%0d EN", v), {31'd0, EN}, {31'd0, tbl[v].en});
            check($sformatf("vec%0d pending", v), {28'd0, pending}, {28'd0, tbl[v].pend});
            check($sformatf("vec%0d overrun", v), {31'd0, overrun}, {31'd0, tbl[v].ov});
        end

        // Test 3: simultaneous presses, ptr starts at 1
        key = 4'b0110;
        wait_en("t3 first EN", 40, n);
        check("t3 first D", {28'd0, D}, 32'h2);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        check("t3 EN after ack", {31'd0, EN}, 32'd0);
        wait_en("t3 second EN", 40, n);
        check("t3 second D", {28'd0, D}, 32'h4);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        check("t3 final ptr", {30'd0, dut.ptr}, 32'd3);
        key = 4'b0000;
        ticks(10);

        // Test 4: move ptr to 2, then all four pending with ack held
        key = 4'b0010;
        wait_en("t4 setup EN", 40, n);
        check("t4 setup D", {28'd0, D}, 32'h2);
        ack = 1'b1; tick(); ack = 1'b0;
        key = 4'b0000;
        ticks(10);
        check("t4 ptr", {30'd0, dut.ptr}, 32'd2);
        seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0001; seq[3] = 4'b0010;
        key = 4'b1111;
        ack = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_en($sformatf("t4 EN grant%0d", g), 40, n);
            check($sformatf("t4 D grant%0d", g), {28'd0, D}, {28'd0, seq[g]});
            if (g > 0) check($sformatf("t4 gap grant%0d", g), n, 32'd2);
        end
        tick();
        check("t4 EN after last ack", {31'd0, EN}, 32'd0);
        ack = 1'b0;
        key = 4'b0000;
        ticks(10);
        check("t4 pending empty", {28'd0, pending}, 32'd0);

        // Test 5: overrun while key3 is held in ISSUE
        key = 4'b1000;
        wait_en("t5 EN", 40, n);
        check("t5 D", {28'd0, D}, 32'h8);
        key = 4'b1001; ticks(8);
        check("t5 pending after press", {28'd0, pending}, 32'h1);
        check("t5 overrun before", {31'd0, overrun}, 32'd0);
        key = 4'b1000; ticks(8);
        key = 4'b1001; ticks(8);
        check("t5 overrun set", {31'd0, overrun}, 32'd1);
        check("t5 D still held", {28'd0, D}, 32'h8);
        key = 4'b0000;
        ack = 1'b1;
        cnt = 0;
        prev_en = EN;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (EN && !prev_en && D == 4'b0001) cnt++;
            prev_en = EN;
        end
        ack = 1'b0;
        check("t5 key0 issued once", cnt, 32'd1);
        check("t5 overrun sticky", {31'd0, overrun}, 32'd1);
        check("t5 pending empty", {28'd0, pending}, 32'd0);

        // Test 6: asynchronous reset between edges during ISSUE
        key = 4'b0100;
        wait_en("t6 EN", 40, n);
        key = 4'b0110; ticks(8);
        check("t6 pending before rst", {28'd0, pending}, 32'h2);
        #2 rst = 1'b1;
        #1;
        check("t6 async D", {28'd0, D}, 32'd0);
        check("t6 async EN", {31'd0, EN}, 32'd0);
        check("t6 async pending", {28'd0, pending}, 32'd0);
        check("t6 async overrun", {31'd0, overrun}, 32'd0);
        model_clear();
        key = 4'b0000;
        ticks(2);
        rst = 1'b0;
        ticks(12);
        check("t6 grant dropped", {27'd0, EN, pending}, 32'd0);

        // Randomised bouncing keys and ack, checked cycle by cycle against the model
        for (int i = 0; i < 4; i++) hold[i] = 0;
        lvl = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1'($urandom_range(0, 1));
                    hold[i] = int'($urandom_range(1, 10));
                end else begin
                    hold[i]--;
                end
            end
            key = lvl;
            ack = ($urandom_range(0, 2) == 0);
            rst = (c == 1500);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
